// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: multi-cycle magnitude comparator.
// The operands are scanned most-significant digit first, DIGIT_W bits per clock,
// behind a start/busy/done handshake. Signed mode and early exit are optional.
module serial_mag_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT_W    = 2,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned ND    = WIDTH / DIGIT_W;
  localparam int unsigned IDX_W = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(ND - 1);
  localparam logic [DIGIT_W-1:0] SIGN_MASK = DIGIT_W'(1) << (DIGIT_W - 1);

  // Reject parameter sets that do not split into whole digits
  if (WIDTH < 2 || DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
    $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT_W");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               sgt_q, sgt_d;
  logic               slt_q, slt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               eq_q, eq_d;

  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic               dig_gt;
  logic               dig_lt;
  logic               first_gt;
  logic               first_lt;
  logic               finish;

  // Current digit sits at the top of the shifted operand copies; bias the sign digit in signed mode
  always_comb begin
    dig_a = a_q[WIDTH-1 -: DIGIT_W];
    dig_b = b_q[WIDTH-1 -: DIGIT_W];
    if (SIGNED != 0 && idx_q == '0) begin
      dig_a = dig_a ^ SIGN_MASK;
      dig_b = dig_b ^ SIGN_MASK;
    end
  end

  // Per-digit compare merged with the sticky first-difference result
  always_comb begin
    dig_gt   = (dig_a > dig_b);
    dig_lt   = (dig_a < dig_b);
    first_gt = sgt_q | (~(sgt_q | slt_q) & dig_gt);
    first_lt = slt_q | (~(sgt_q | slt_q) & dig_lt);
    finish   = (idx_q == LAST_IDX) || (EARLY_EXIT != 0 && (dig_gt || dig_lt));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    sgt_d   = sgt_q;
    slt_d   = slt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          sgt_d   = 1'b0;
          slt_d   = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (finish) begin
          gt_d    = first_gt;
          lt_d    = first_lt;
          eq_d    = ~(first_gt | first_lt);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          sgt_d = first_gt;
          slt_d = first_lt;
          a_d   = a_q << DIGIT_W;
          b_d   = b_q << DIGIT_W;
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      sgt_q   <= 1'b0;
      slt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      sgt_q   <= sgt_d;
      slt_q   <= slt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

`ifndef SYNTHESIS
  // Result is one-hot when reported, and cleared while a compare is running
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) done |-> $onehot({gt, lt, eq}));
  a_busy_clear:  assert property (@(posedge clk) disable iff (!rst_n) busy |-> ({gt, lt, eq} == 3'b000));
  a_done_idle:   assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
`endif

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: unsigned early-exit, signed and
// fixed-latency instances sharing clock, reset and operand buses.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [2:0] gt_w;
  logic [2:0] lt_w;
  logic [2:0] eq_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8), .DIGIT_W(2), .SIGNED(0), .EARLY_EXIT(1)) u_uns (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .a(a_r), .b(b_r),
    .busy(busy_w[0]), .done(done_w[0]), .gt(gt_w[0]), .lt(lt_w[0]), .eq(eq_w[0])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT_W(2), .SIGNED(1), .EARLY_EXIT(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .a(a_r), .b(b_r),
    .busy(busy_w[1]), .done(done_w[1]), .gt(gt_w[1]), .lt(lt_w[1]), .eq(eq_w[1])
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT_W(2), .SIGNED(0), .EARLY_EXIT(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .a(a_r), .b(b_r),
    .busy(busy_w[2]), .done(done_w[2]), .gt(gt_w[2]), .lt(lt_w[2]), .eq(eq_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] res(input int u);
    return {gt_w[u], lt_w[u], eq_w[u]};
  endfunction

  // Called at a negedge: present operands, let the next posedge accept, check the busy window
  task automatic launch(input int u, input logic [7:0] av, input logic [7:0] bv, input string tag);
    a_r        = av;
    b_r        = bv;
    start_r[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[u] = 1'b0;
    chk({tag, "/acc_busy"}, 32'(busy_w[u]), 32'(1));
    chk({tag, "/acc_res"},  32'(res(u)),    32'(0));
  endtask

  // Count edges after the accepting edge until done; optionally poke start while busy
  task automatic wait_done(input int u, input int exp_n, input logic [2:0] exp_res,
                           input bit poke, input string tag);
    int n = 0;
    while (done_w[u] !== 1'b1 && n < 20) begin
      if (poke && n == 0) begin
        a_r        = 8'hFF;
        b_r        = 8'h00;
        start_r[u] = 1'b1;
      end
      @(negedge clk);
      start_r[u] = 1'b0;
      n++;
    end
    chk({tag, "/lat"},  32'(n),         32'(exp_n));
    chk({tag, "/res"},  32'(res(u)),    32'(exp_res));
    chk({tag, "/busy"}, 32'(busy_w[u]), 32'(0));
  endtask

  task automatic do_cmp(input int u, input logic [7:0] av, input logic [7:0] bv,
                        input int exp_n, input logic [2:0] exp_res, input bit poke,
                        input string tag);
    @(negedge clk);
    launch(u, av, bv, tag);
    wait_done(u, exp_n, exp_res, poke, tag);
    @(negedge clk);
    chk({tag, "/pulse"}, 32'(done_w[u]), 32'(0));
    chk({tag, "/hold"},  32'(res(u)),    32'(exp_res));
  endtask

  initial begin
    rst_n   = 1'b0;
    start_r = 3'b000;
    a_r     = 8'h00;
    b_r     = 8'h00;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk($sformatf("reset%0d", u), 32'({busy_w[u], done_w[u], res(u)}), 32'(0));
    rst_n = 1'b1;

    // Unsigned, early exit ({gt,lt,eq})
    do_cmp(0, 8'hA5, 8'hA5, 4, 3'b001, 1'b0, "u_eq");
    do_cmp(0, 8'h80, 8'h7F, 1, 3'b100, 1'b0, "u_gt_d0");
    do_cmp(0, 8'hA4, 8'hA5, 4, 3'b010, 1'b0, "u_lt_d3");
    do_cmp(0, 8'h00, 8'hFF, 1, 3'b010, 1'b0, "u_lt_d0");
    do_cmp(0, 8'h3C, 8'h34, 3, 3'b100, 1'b0, "u_gt_d2");

    // Signed, early exit
    do_cmp(1, 8'h80, 8'h7F, 1, 3'b010, 1'b0, "s_min_max");
    do_cmp(1, 8'hFE, 8'hFD, 4, 3'b100, 1'b0, "s_m2_m3");
    do_cmp(1, 8'hFF, 8'h01, 1, 3'b010, 1'b0, "s_m1_p1");
    do_cmp(1, 8'h05, 8'h05, 4, 3'b001, 1'b0, "s_eq");

    // Fixed latency: first difference sticks despite later reversed digits
    do_cmp(2, 8'h40, 8'h3F, 4, 3'b100, 1'b0, "f_sticky");
    do_cmp(2, 8'h3C, 8'h34, 4, 3'b100, 1'b0, "f_gt_d2");

    // Back-to-back: second start in the done cycle
    @(negedge clk);
    launch(2, 8'h80, 8'h7F, "b2b1");
    wait_done(2, 4, 3'b100, 1'b0, "b2b1");
    launch(2, 8'h01, 8'h02, "b2b2");
    wait_done(2, 4, 3'b010, 1'b0, "b2b2");
    @(negedge clk);
    chk("b2b2/pulse", 32'(done_w[2]), 32'(0));

    // start while busy is ignored
    do_cmp(0, 8'hA4, 8'hA5, 4, 3'b010, 1'b1, "busy_start");

    // Reset mid-run aborts without a done pulse
    @(negedge clk);
    launch(0, 8'hA5, 8'hA5, "rst_run");
    @(negedge clk);
    chk("rst_run/busy_pre", 32'(busy_w[0]), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_run/async", 32'({busy_w[0], done_w[0], res(0)}), 32'(0));
    repeat (3) @(negedge clk);
    chk("rst_run/no_done", 32'({busy_w[0], done_w[0], res(0)}), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_run/idle", 32'({busy_w[0], done_w[0], res(0)}), 32'(0));
    do_cmp(0, 8'h80, 8'h7F, 1, 3'b100, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator and successor to the combinational 3-bit gate-level comparator.
- Compares two WIDTH-bit operands most-significant digit first, DIGIT_W bits per clock.
- Supports an optional signed (two's complement) mode and early termination on the first differing digit.
- Sits behind a start/done handshake so wide compares can share a datapath without a wide single-cycle cone.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥2 and an integer multiple of DIGIT_W (elaboration error otherwise).
- DIGIT_W, 2: bits compared per clock cycle; 1 ≤ DIGIT_W ≤ WIDTH.
- SIGNED, 0: 0 = unsigned compare; 1 = two's complement compare.
- EARLY_EXIT, 1: 1 = finish on the first unequal digit; 0 = always scan all digits, giving fixed latency.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while busy=0
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- busy  out  1  compare in progress
- done  out  1  one-cycle pulse; result valid
- gt  out  1  A > B, held until the next accepted start
- lt  out  1  A < B, held
- eq  out  1  A == B, held

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, gt=0, lt=0, eq=0.
  - Internal operand and digit-index registers are cleared.
  - Deassertion takes effect at the next clk edge.
- Definitions:
  - ND = WIDTH/DIGIT_W.
  - Digit i (i = 0..ND-1) = bits [WIDTH-1-i*DIGIT_W -: DIGIT_W], so digit 0 holds the MSB.
- States: IDLE, RUN.
- IDLE:
  - On an edge with start=1: capture a and b; clear gt/lt/eq; set index=0; busy=1; go to RUN.
  - start=0: remain in IDLE; gt/lt/eq hold their values.
- RUN, one digit per edge:
  - Compare digit[index] of A and B as unsigned DIGIT_W-bit values.
  - If SIGNED=1 and index=0, invert the top bit of both digits before comparing (sign correction).
  - Record the per-digit result as greater, less or equal.
- Termination:
  - Digits unequal and EARLY_EXIT=1: register gt/lt from this digit; done=1, busy=0; go to IDLE.
  - Digits unequal and EARLY_EXIT=0: latch the first unequal result in a sticky register; later digits cannot override it; continue scanning.
  - Last digit (index=ND-1): final result = the sticky/first unequal result, or eq=1 if every digit matched; done=1, busy=0; go to IDLE.
  - Otherwise: index += 1.
- Exactly one of gt/lt/eq is high after any done; all three are 0 from the accepting edge until done.
- Latency:
  - Accepting edge k; digit i is evaluated at edge k+1+i.
  - done is high for the single cycle following edge k+N.
  - N = ND when EARLY_EXIT=0 or the operands are equal; otherwise N = 1 + index of the first differing digit.
- done is a one-cycle pulse; it deasserts on the next edge regardless of start.
- start while busy=1 is ignored: no capture and no effect on the current compare.
- start=1 in the done cycle (busy=0) is accepted: back-to-back operation with zero idle cycles.
- a and b may change freely after capture; only the captured copies are used.
- Reset mid-RUN aborts the compare; no done pulse is produced for the aborted operation.
- DIGIT_W=WIDTH degenerates to a single-cycle RUN with N=1.

Test Plan:
- Unsigned equal, defaults (WIDTH=8, DIGIT_W=2): a=0xA5, b=0xA5, start at edge k → done in the cycle after edge k+4; eq=1, gt=0, lt=0; busy high for cycles k..k+3.
- Early exit, unsigned, defaults: a=0x80, b=0x7F → done after edge k+1; gt=1. With a=0xA4, b=0xA5 → done after edge k+4; lt=1.
- Signed sign-correction (SIGNED=1, defaults otherwise):
  - a=0x80 (-128), b=0x7F (+127) → lt=1, N=1.
  - a=0xFE (-2), b=0xFD (-3) → gt=1, N=4.
- Fixed latency (EARLY_EXIT=0): a=0x80, b=0x7F → done after edge k+4 with gt=1, not overridden by later digits. Asserting start again during the done cycle with a=0x01, b=0x02 is accepted; the second done follows 4 edges later with lt=1.
- Handshake and reset:
  - Start pulse at edge k+1 during RUN with different a/b → ignored; the first result is unchanged.
  - rst_n low mid-RUN → busy/gt/lt/eq/done go to 0 immediately; no done pulse; the next start after release completes normally.
